myram_arbiter: RTL and testbench
================================

Name: myram_arbiter

Overview:
- Arbitrates two requesters (A, B) onto the single-port 256x32 byte-enabled on-chip RAM (`myRAM`) used for PTP timestamp/descriptor storage.
- Issues one access per cycle with registered RAM drive and round-robin fairness.
- Returns read data to the requester that issued the read.
- Contains a clear sequencer that zero-fills the whole RAM after reset or on request.

Parameters:
- ADDR_W, 8, RAM address width; depth = 2**ADDR_W.
- DATA_W, 32, data width.
- BE_W, 4, byte-enable width (DATA_W/8).
- RD_LATENCY, 1, RAM clock edges from address sample to valid q (1 or 2).
- CLEAR_ON_RESET, 1, enter CLEAR state when reset releases.

Ports:
- clock  in  1  single clock for block and RAM.
- reset  in  1  synchronous, active-high.
- clear_req  in  1  pulse: start zero-fill.
- clear_busy  out  1  high while in CLEAR.
- clear_done  out  1  one-cycle pulse on the final clear write.
- a_valid  in  1  requester A command valid.
- a_ready  out  1  A command accepted this cycle.
- a_wren  in  1  1=write, 0=read.
- a_address  in  ADDR_W  A address.
- a_data  in  DATA_W  A write data.
- a_byteena  in  BE_W  A write byte mask.
- a_rvalid  out  1  A read data valid.
- a_rdata  out  DATA_W  A read data.
- b_*  same set as a_*, for requester B.
- ram_address  out  ADDR_W  to myRAM address.
- ram_data  out  DATA_W  to myRAM data.
- ram_wren  out  1  to myRAM wren.
- ram_byteena  out  BE_W  to myRAM byteena.
- ram_q  in  DATA_W  from myRAM q.

Behaviour:
- **Reset (synchronous, active-high):**
  - All outputs 0; priority pointer set to A.
  - Read-tag pipeline flushed; in-flight reads never return.
  - State after reset is CLEAR if CLEAR_ON_RESET=1, else SERVE.
  - Reset asserted mid-clear restarts the clear from address 0 (when CLEAR_ON_RESET=1).
- **State SERVE:**
  - x_ready is combinational: state==SERVE & x_valid & grant==x. Acceptance = valid & ready.
  - If only one requester is valid, it is granted.
  - If both are valid, the priority pointer wins. After any grant, the pointer moves to the other requester.
  - At most one acceptance per cycle; the loser's ready stays low.
  - Requesters hold command fields stable until accepted.
- **RAM drive:**
  - On acceptance at edge t, ram_address, ram_data, ram_wren (=x_wren) and ram_byteena are registered; the RAM samples them at edge t+1.
  - In cycles with no acceptance: ram_wren=0 and the other fields hold their previous values.
  - A read drives ram_byteena with the requester's value; the RAM ignores it.
  - A write with byteena=0 is issued anyway; memory is unchanged.
- **Read return:**
  - A tag pipeline of depth 1+RD_LATENCY carries {valid, requester id} for each accepted read.
  - x_rvalid pulses one cycle, 1+RD_LATENCY cycles after acceptance. x_rdata = ram_q, unregistered.
  - x_rdata is don't-care while x_rvalid=0; the bench must only check it when rvalid=1.
  - Writes produce no response.
  - Back-to-back reads, including alternating A/B, return in issue order, one per cycle.
- **Read-after-write to the same address:**
  - A write accepted at t is visible to a read accepted at t+1 or later. No bypass is needed because the RAM order is preserved.
- **State CLEAR:**
  - x_ready=0; clear_busy=1; an 8-bit clear counter starts at 0.
  - Each cycle issues ram_wren=1, ram_address=counter, ram_data=0, ram_byteena=all ones, then increments the counter.
  - On the write to address 2**ADDR_W-1: pulse clear_done, return to SERVE next cycle, and reset the priority pointer to A.
  - The clear takes exactly 2**ADDR_W cycles (256 by default).
- **clear_req handling:**
  - clear_req in SERVE → CLEAR next cycle. A command accepted in the same cycle is still issued, and its read still returns.
  - Read returns already in flight at CLEAR entry are delivered normally.
  - clear_req during CLEAR is ignored.
  - clear_req and a valid request in the same cycle: the request may be accepted that cycle, then the clear starts.

Decomposition:
- **Package myram_pkg:**
  - Constants ADDR_W, DATA_W, BE_W, DEPTH.
  - State enum {SERVE, CLEAR}.
  - Requester-id type {REQ_A, REQ_B}.
- **Sub-module myram_rd_tag_pipe:** a parameterised shift register of {valid, id}, depth 1+RD_LATENCY, with synchronous flush.

Test Plan:
- Reset with CLEAR_ON_RESET=1 → clear_busy high for 256 cycles, clear_done once on the cycle writing address 0xFF; then a read of address 0x37 → a_rdata=0x00000000 on a_rvalid, 2 cycles after acceptance (RD_LATENCY=1).
- A writes 0xDEADBEEF to 0x10 with byteena=4'b1111, then writes 0x11223344 to 0x10 with byteena=4'b0101; B reads 0x10 → b_rdata=0xDE22BE44, a_rvalid stays 0.
- A and B both hold valid for 6 cycles (reads to 0x01 and 0x02) → grants alternate A,B,A,B,A,B; each rvalid carries the matching data, with no cross-delivery.
- B write to 0x20 accepted at cycle t, A read to 0x20 accepted at t+1 → A receives the new value.
- clear_req asserted while A read of 0x05 (holding 0xCAFEF00D) is accepted → a_rvalid still returns 0xCAFEF00D; a subsequent read after clear_done returns 0.
- Reset pulsed at clear counter 0x80 → clear restarts at 0x00; no rvalid issued for reads in flight at reset.

Source files
------------

// File: rtl/myram_pkg.sv
// Shared constants and types for the myRAM arbiter slice.
package myram_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  typedef enum logic {
    SERVE = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/myram_rd_tag_pipe.sv
// Shift register of {valid, requester id} tracking reads in flight to myRAM.
module myram_rd_tag_pipe
  import myram_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic    clock,
  input  logic    flush,
  input  logic    in_valid,
  input  req_id_t in_id,
  output logic    out_valid,
  output req_id_t out_id
);

  logic    vld [STAGES];
  req_id_t ids [STAGES];

  // Advance tags one stage per cycle; flush drops everything in flight.
  always_ff @(posedge clock) begin
    if (flush) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        vld[i] <= 1'b0;
        ids[i] <= REQ_A;
      end
    end else begin
      vld[0] <= in_valid;
      ids[0] <= in_id;
      for (int unsigned i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        ids[i] <= ids[i-1];
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign out_id    = ids[STAGES-1];

endmodule

// File: rtl/myram_arbiter.sv
// Two-requester round-robin arbiter onto the single-port myRAM, with a
// zero-fill clear sequencer and per-requester read return.
module myram_arbiter #(
  parameter int unsigned ADDR_W         = myram_pkg::ADDR_W,
  parameter int unsigned DATA_W         = myram_pkg::DATA_W,
  parameter int unsigned BE_W           = myram_pkg::BE_W,
  parameter int unsigned RD_LATENCY     = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_wren,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] a_data,
  input  logic [BE_W-1:0]   a_byteena,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_wren,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [DATA_W-1:0] b_data,
  input  logic [BE_W-1:0]   b_byteena,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [BE_W-1:0]   ram_byteena,
  input  logic [DATA_W-1:0] ram_q
);

  import myram_pkg::*;

  state_t            state;
  req_id_t           prio;
  logic [ADDR_W-1:0] clr_cnt;
  logic              serving;
  logic              grant_a;
  logic              grant_b;
  logic              last_clr;
  logic              rd_issue;
  req_id_t           rd_id;
  logic              tag_valid;
  req_id_t           tag_id;

  assign serving  = (state == SERVE) && !reset;
  assign last_clr = (clr_cnt == '1);

  // Lone requester wins outright; on contention the priority pointer decides.
  always_comb begin
    grant_a = a_valid && (!b_valid || prio == REQ_A);
    grant_b = b_valid && (!a_valid || prio == REQ_B);
  end

  assign a_ready    = serving && grant_a;
  assign b_ready    = serving && grant_b;
  assign clear_busy = (state == CLEAR) && !reset;

  // Mode, round-robin pointer and clear address counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR_ON_RESET ? CLEAR : SERVE;
      prio    <= REQ_A;
      clr_cnt <= '0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (last_clr) begin
        state <= SERVE;
        prio  <= REQ_A;
      end
    end else begin
      if (a_ready) begin
        prio <= REQ_B;
      end else if (b_ready) begin
        prio <= REQ_A;
      end
      if (clear_req) begin
        state   <= CLEAR;
        clr_cnt <= '0;
      end
    end
  end

  // Registered RAM drive: clear writes, accepted commands, or idle (wren low, fields held).
  always_ff @(posedge clock) begin
    if (reset) begin
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      ram_byteena <= '0;
      clear_done  <= 1'b0;
    end else begin
      ram_wren   <= 1'b0;
      clear_done <= 1'b0;
      if (state == CLEAR) begin
        ram_address <= clr_cnt;
        ram_data    <= '0;
        ram_wren    <= 1'b1;
        ram_byteena <= '1;
        clear_done  <= last_clr;
      end else if (a_ready) begin
        ram_address <= a_address;
        ram_data    <= a_data;
        ram_wren    <= a_wren;
        ram_byteena <= a_byteena;
      end else if (b_ready) begin
        ram_address <= b_address;
        ram_data    <= b_data;
        ram_wren    <= b_wren;
        ram_byteena <= b_byteena;
      end
    end
  end

  assign rd_issue = (a_ready && !a_wren) || (b_ready && !b_wren);
  assign rd_id    = b_ready ? REQ_B : REQ_A;

  // One stage for the registered drive plus RD_LATENCY stages inside the RAM.
  myram_rd_tag_pipe #(
    .STAGES(1 + RD_LATENCY)
  ) u_tag_pipe (
    .clock    (clock),
    .flush    (reset),
    .in_valid (rd_issue),
    .in_id    (rd_id),
    .out_valid(tag_valid),
    .out_id   (tag_id)
  );

  assign a_rvalid = tag_valid && (tag_id == REQ_A) && !reset;
  assign b_rvalid = tag_valid && (tag_id == REQ_B) && !reset;
  assign a_rdata  = a_rvalid ? ram_q : '0;
  assign b_rdata  = b_rvalid ? ram_q : '0;

endmodule

// File: tb/tb_myram_arbiter.sv
// Self-checking bench for myram_arbiter: behavioural myRAM, transaction-level
// reference model, directed scenarios and a randomized phase.
module tb_myram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_req;
  logic        clear_busy, clear_done;
  logic        a_valid, a_ready, a_wren, a_rvalid;
  logic [7:0]  a_address;
  logic [31:0] a_data, a_rdata;
  logic [3:0]  a_byteena;
  logic        b_valid, b_ready, b_wren, b_rvalid;
  logic [7:0]  b_address;
  logic [31:0] b_data, b_rdata;
  logic [3:0]  b_byteena;
  logic [7:0]  ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [3:0]  ram_byteena;
  logic [31:0] ram_q;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  myram_arbiter #(
    .ADDR_W(8), .DATA_W(32), .BE_W(4), .RD_LATENCY(1), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock(clk), .reset(reset), .clear_req(clear_req),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .a_valid(a_valid), .a_ready(a_ready), .a_wren(a_wren), .a_address(a_address),
    .a_data(a_data), .a_byteena(a_byteena), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_wren(b_wren), .b_address(b_address),
    .b_data(b_data), .b_byteena(b_byteena), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_byteena(ram_byteena), .ram_q(ram_q)
  );

  // Behavioural myRAM: byte-masked write, registered read (one edge of latency).
  logic [31:0] ram_mem [256];
  bit          ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      foreach (ram_mem[i]) ram_mem[i] <= $urandom;
      ram_init <= 1'b1;
    end else if (ram_wren) begin
      for (int k = 0; k < 4; k++)
        if (ram_byteena[k]) ram_mem[ram_address][8*k +: 8] <= ram_data[8*k +: 8];
    end
    ram_q <= ram_mem[ram_address];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    bit          is_b;
    logic [31:0] data;
  } ret_t;

  ret_t        pend[$];
  logic [31:0] mdl [256];
  int          cyc       = 0;
  int          clr_left  = 0;
  bit          turn_b    = 1'b0;
  bit          done_next = 1'b0;
  bit          drv_next  = 1'b0;
  bit          drv_wr;
  logic [7:0]  drv_addr;
  logic [31:0] drv_data;
  logic [3:0]  drv_be;

  always @(negedge clk) begin
    bit          ea, eb, exp_ra, exp_rb;
    logic [31:0] exp_d, wd;
    logic [7:0]  wa;
    logic [3:0]  wbe;
    ret_t        r;
    if (reset) begin
      check("rst_ready", {a_ready, b_ready}, 2'b00);
      check("rst_rvalid", {a_rvalid, b_rvalid}, 2'b00);
      check("rst_busy", clear_busy, 1'b0);
      pend.delete();
      clr_left  = 256;
      turn_b    = 1'b0;
      done_next = 1'b0;
      drv_next  = 1'b0;
      foreach (mdl[i]) mdl[i] = '0;
    end else begin
      exp_ra = 1'b0;
      exp_rb = 1'b0;
      exp_d  = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        exp_rb = r.is_b;
        exp_ra = !r.is_b;
        exp_d  = r.data;
      end
      check("rvalid", {a_rvalid, b_rvalid}, {exp_ra, exp_rb});
      if (a_rvalid && exp_ra) check("a_rdata", a_rdata, exp_d);
      if (b_rvalid && exp_rb) check("b_rdata", b_rdata, exp_d);
      check("clear_done", clear_done, done_next);
      check("ram_wren", ram_wren, drv_next && drv_wr);
      if (drv_next)
        check("ram_drive", {ram_address, ram_data, ram_byteena}, {drv_addr, drv_data, drv_be});
      done_next = 1'b0;
      drv_next  = 1'b0;
      if (clr_left > 0) begin
        check("busy", clear_busy, 1'b1);
        check("ready_in_clear", {a_ready, b_ready}, 2'b00);
        drv_next = 1'b1;
        drv_wr   = 1'b1;
        drv_addr = 8'(256 - clr_left);
        drv_data = '0;
        drv_be   = 4'hF;
        clr_left--;
        if (clr_left == 0) begin
          done_next = 1'b1;
          turn_b    = 1'b0;
        end
      end else begin
        check("busy", clear_busy, 1'b0);
        ea = a_valid && (!b_valid || !turn_b);
        eb = b_valid && !ea;
        check("ready", {a_ready, b_ready}, {ea, eb});
        if (ea || eb) begin
          turn_b   = ea;
          drv_next = 1'b1;
          drv_wr   = ea ? a_wren : b_wren;
          wa       = ea ? a_address : b_address;
          wd       = ea ? a_data : b_data;
          wbe      = ea ? a_byteena : b_byteena;
          drv_addr = wa;
          drv_data = wd;
          drv_be   = wbe;
          if (drv_wr) begin
            for (int k = 0; k < 4; k++)
              if (wbe[k]) mdl[wa][8*k +: 8] = wd[8*k +: 8];
          end else begin
            pend.push_back('{cyc + 2, eb, mdl[wa]});
          end
        end
        if (clear_req) begin
          clr_left = 256;
          foreach (mdl[i]) mdl[i] = '0;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cmd(input bit is_b, input bit wr, input logic [7:0] addr,
                     input logic [31:0] data, input logic [3:0] be, input bit clr);
    bit ok = 1'b0;
    if (is_b) begin
      b_valid = 1'b1; b_wren = wr; b_address = addr; b_data = data; b_byteena = be;
    end else begin
      a_valid = 1'b1; a_wren = wr; a_address = addr; a_data = data; a_byteena = be;
    end
    clear_req = clr;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = is_b ? b_ready : a_ready;
      @(posedge clk); #1;
      clear_req = 1'b0;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("accept_in_time", ok, 1'b1);
  endtask

  task automatic wait_rd(input bit is_b, input logic [31:0] exp, input string nm);
    bit          seen = 1'b0;
    logic [31:0] got  = '0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (is_b ? b_rvalid : a_rvalid) begin
        seen = 1'b1;
        got  = is_b ? b_rdata : a_rdata;
      end
    end
    check({nm, "_seen"}, seen, 1'b1);
    if (seen) check(nm, got, exp);
    @(posedge clk); #1;
  endtask

  task automatic wait_clear_end(input string nm);
    bit fin = 1'b0;
    for (int i = 0; i < 700 && !fin; i++) begin
      @(negedge clk);
      fin = !clear_busy;
    end
    check(nm, fin, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed + random scenarios ----------------
  initial begin
    int         nb, nd, na, nrv;
    bit         acc_a, acc_b, got_first;
    logic [5:0] pat;
    logic [7:0] first_addr;

    reset = 1'b1; clear_req = 1'b0;
    a_valid = 1'b0; a_wren = 1'b0; a_address = '0; a_data = '0; a_byteena = '0;
    b_valid = 1'b0; b_wren = 1'b0; b_address = '0; b_data = '0; b_byteena = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Clear after reset: 256 busy cycles, single done pulse on the 0xFF write.
    nb = 0; nd = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (clear_busy) nb++;
      if (clear_done) begin
        nd++;
        check("done_addr", {ram_wren, ram_address}, {1'b1, 8'hFF});
      end
      if (!clear_busy && nd > 0) break;
    end
    check("clear_cycles", nb, 256);
    check("clear_done_count", nd, 1);
    @(posedge clk); #1;

    cmd(1'b0, 1'b0, 8'h37, '0, 4'hF, 1'b0);
    wait_rd(1'b0, 32'h0000_0000, "read_after_clear");

    // Contention: pointer lands on A after these two writes.
    cmd(1'b0, 1'b1, 8'h01, 32'hAAAA_0001, 4'hF, 1'b0);
    cmd(1'b1, 1'b1, 8'h02, 32'hBBBB_0002, 4'hF, 1'b0);
    a_valid = 1'b1; a_wren = 1'b0; a_address = 8'h01;
    b_valid = 1'b1; b_wren = 1'b0; b_address = 8'h02;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat = {pat[4:0], a_ready};
      @(posedge clk); #1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("alt_grants", pat, 6'b101010);
    idle(4);

    // Byte-enable merge.
    cmd(1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    cmd(1'b0, 1'b1, 8'h10, 32'h1122_3344, 4'b0101, 1'b0);
    cmd(1'b1, 1'b0, 8'h10, '0, 4'h0, 1'b0);
    wait_rd(1'b1, 32'hDE22_BE44, "byteena_merge");

    // Write at t, read at t+1.
    cmd(1'b1, 1'b1, 8'h20, 32'h5A5A_1234, 4'hF, 1'b0);
    cmd(1'b0, 1'b0, 8'h20, '0, 4'hF, 1'b0);
    wait_rd(1'b0, 32'h5A5A_1234, "raw_next_cycle");

    // Read accepted together with clear_req still returns pre-clear data.
    cmd(1'b0, 1'b1, 8'h05, 32'hCAFE_F00D, 4'hF, 1'b0);
    cmd(1'b0, 1'b0, 8'h05, '0, 4'hF, 1'b1);
    wait_rd(1'b0, 32'hCAFE_F00D, "read_at_clear_req");
    wait_clear_end("clear_req_finish");
    cmd(1'b0, 1'b0, 8'h05, '0, 4'hF, 1'b0);
    wait_rd(1'b0, 32'h0000_0000, "read_after_req_clear");

    // Randomized traffic; requesters hold commands until accepted.
    acc_a = 1'b0; acc_b = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      @(posedge clk); #1;
      if (!a_valid || acc_a) begin
        a_valid = ($urandom_range(0, 9) < 6); a_wren = 1'($urandom_range(0, 1));
        a_address = 8'($urandom_range(0, 15)); a_data = $urandom; a_byteena = 4'($urandom);
      end
      if (!b_valid || acc_b) begin
        b_valid = ($urandom_range(0, 9) < 6); b_wren = 1'($urandom_range(0, 1));
        b_address = 8'($urandom_range(0, 15)); b_data = $urandom; b_byteena = 4'($urandom);
      end
      clear_req = ($urandom_range(0, 299) == 0);
      reset     = ($urandom_range(0, 999) == 0);
    end
    a_valid = 1'b0; b_valid = 1'b0; clear_req = 1'b0; reset = 1'b0;
    wait_clear_end("random_drain");
    idle(3);

    // Reset in the middle of a clear restarts it from address 0.
    clear_req = 1'b1;
    idle(1);
    clear_req = 1'b0;
    na = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      na++;
      if (ram_wren && ram_address == 8'h80) break;
    end
    check("reach_0x80", na < 400, 1'b1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    nb = 0; got_first = 1'b0; first_addr = '1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (clear_busy) nb++;
      if (!got_first && ram_wren) begin
        got_first = 1'b1;
        first_addr = ram_address;
      end
      if (!clear_busy) break;
    end
    check("restart_first_addr", first_addr, 8'h00);
    check("restart_cycles", nb, 256);
    @(posedge clk); #1;

    // A read in flight when reset hits never returns.
    cmd(1'b0, 1'b0, 8'h05, '0, 4'hF, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    nrv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (a_rvalid || b_rvalid) nrv++;
    end
    check("flushed_rvalid", nrv, 0);
    @(posedge clk); #1;
    wait_clear_end("reset_clear_finish");
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
